// File: rtl/bitpack_gamma1_pkg.sv
// Shared dilithium parameters for the gamma1 bit packer: vector/poly sizes, field widths, FSM states.
package bitpack_gamma1_pkg;

    localparam int unsigned L              = 7;
    localparam int unsigned N              = 256;
    localparam int unsigned GAMMA1         = 19;
    localparam int unsigned COEFF_WIDTH    = GAMMA1 + 1;
    localparam int unsigned DATA_OUT_BITS  = 64;
    localparam int unsigned WORDS_PER_POLY = N * COEFF_WIDTH / DATA_OUT_BITS;
    localparam int unsigned COEFF_IN_W     = 24;
    localparam int unsigned BUF_W          = 128;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/bit_accumulator.sv
// LSB-first bit buffer: appends IN_W-bit fields at the fill point and pops OUT_W-bit words from the bottom.
module bit_accumulator #(
    parameter int unsigned IN_W   = 20,
    parameter int unsigned OUT_W  = 64,
    parameter int unsigned BUF_W  = 128,
    parameter int unsigned FILL_W = $clog2(BUF_W + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              push,
    input  logic [IN_W-1:0]   push_data,
    input  logic              pop,
    output logic [OUT_W-1:0]  data,
    output logic              valid,
    output logic [FILL_W-1:0] fill,
    output logic              valid_nxt_c
);

    logic [BUF_W-1:0]  buf_q, buf_d, shifted_c;
    logic [FILL_W-1:0] fill_q, fill_d, fill_pop_c;
    logic              valid_q;

    // Pop happens before append so a same-cycle push lands at the post-pop fill point.
    always_comb begin
        shifted_c  = buf_q;
        fill_pop_c = fill_q;
        if (pop) begin
            shifted_c  = buf_q >> OUT_W;
            fill_pop_c = fill_q - FILL_W'(OUT_W);
        end
        buf_d  = shifted_c;
        fill_d = fill_pop_c;
        if (push) begin
            buf_d  = shifted_c | (BUF_W'(push_data) << fill_pop_c);
            fill_d = fill_pop_c + FILL_W'(IN_W);
        end
        if (clr) begin
            buf_d  = '0;
            fill_d = '0;
        end
        valid_nxt_c = (fill_d >= FILL_W'(OUT_W));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            buf_q   <= '0;
            fill_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            buf_q   <= buf_d;
            fill_q  <= fill_d;
            valid_q <= valid_nxt_c;
        end
    end

    assign data  = buf_q[OUT_W-1:0];
    assign valid = valid_q;
    assign fill  = fill_q;

endmodule

// File: rtl/bitpack_gamma1.sv
// Streams a vector of signed coefficients from RAM, maps each to 2^GAMMA1 - c and packs the fields into 64-bit words.
// Optional build macro BITPACK_RANGE_CHECK_EN adds a sticky out-of-range flag on err.
module bitpack_gamma1
    import bitpack_gamma1_pkg::*;
#(
    parameter int unsigned L             = bitpack_gamma1_pkg::L,
    parameter int unsigned N             = bitpack_gamma1_pkg::N,
    parameter int unsigned GAMMA1        = bitpack_gamma1_pkg::GAMMA1,
    parameter int unsigned COEFF_WIDTH   = GAMMA1 + 1,
    parameter int unsigned DATA_OUT_BITS = bitpack_gamma1_pkg::DATA_OUT_BITS,
    parameter int unsigned ADDR_WIDTH    = $clog2(L * N)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    output logic                     done,
    output logic                     busy,
    output logic [ADDR_WIDTH-1:0]    addr_vector_y,
    input  logic [COEFF_IN_W-1:0]    dout_vector_y,
    output logic [DATA_OUT_BITS-1:0] out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_poly_last,
    output logic                     err
);

    localparam int unsigned NUM_COEFFS  = L * N;
    localparam int unsigned TOTAL_WORDS = NUM_COEFFS * COEFF_WIDTH / DATA_OUT_BITS;
    localparam int unsigned POLY_WORDS  = N * COEFF_WIDTH / DATA_OUT_BITS;
    localparam int unsigned RD_W        = $clog2(NUM_COEFFS + 1);
    localparam int unsigned WORD_W      = $clog2(TOTAL_WORDS + 1);
    localparam int unsigned PW          = $clog2(POLY_WORDS + 1);
    localparam int unsigned FILL_W      = $clog2(BUF_W + 1);
    localparam int unsigned CMT_W       = FILL_W + 1;

    logic [1:0]             state_q, state_d;
    logic [RD_W-1:0]        rd_cnt_q, rd_cnt_d, rd_base_c;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic                   iss_q, dat_q, issue_c, clr_c;
    logic [WORD_W-1:0]      word_cnt_q, word_cnt_d;
    logic [PW-1:0]          poly_cnt_q, poly_cnt_d;
    logic                   busy_q, busy_d, done_q, done_d, poly_last_q, poly_last_d;
    logic                   start_ok_c, accept_c;
    logic [CMT_W-1:0]       committed_c;
    logic [COEFF_WIDTH-1:0] t_c;

    logic                     acc_valid, acc_valid_nxt_c;
    logic [DATA_OUT_BITS-1:0] acc_data;
    logic [FILL_W-1:0]        acc_fill;

    assign start_ok_c = start && (state_q == ST_IDLE);
    assign accept_c   = acc_valid && out_ready;
    assign t_c        = COEFF_WIDTH'(COEFF_IN_W'(1 << GAMMA1) - dout_vector_y);

    // Bits already buffered plus those still in the two-stage read pipeline, net of this cycle's pop.
    assign committed_c = CMT_W'(acc_fill)
                       + (iss_q ? CMT_W'(COEFF_WIDTH) : CMT_W'(0))
                       + (dat_q ? CMT_W'(COEFF_WIDTH) : CMT_W'(0))
                       - (accept_c ? CMT_W'(DATA_OUT_BITS) : CMT_W'(0));

    bit_accumulator #(
        .IN_W   (COEFF_WIDTH),
        .OUT_W  (DATA_OUT_BITS),
        .BUF_W  (BUF_W),
        .FILL_W (FILL_W)
    ) u_acc (
        .clk         (clk),
        .rst         (rst),
        .clr         (clr_c),
        .push        (dat_q),
        .push_data   (t_c),
        .pop         (accept_c),
        .data        (acc_data),
        .valid       (acc_valid),
        .fill        (acc_fill),
        .valid_nxt_c (acc_valid_nxt_c)
    );

    always_comb begin
        state_d    = state_q;
        rd_cnt_d   = rd_cnt_q;
        rd_base_c  = rd_cnt_q;
        addr_d     = addr_q;
        issue_c    = 1'b0;
        clr_c      = 1'b0;
        word_cnt_d = word_cnt_q;
        poly_cnt_d = poly_cnt_q;

        if (accept_c) begin
            word_cnt_d = word_cnt_q + WORD_W'(1);
            poly_cnt_d = (poly_cnt_q == PW'(POLY_WORDS - 1)) ? PW'(0) : poly_cnt_q + PW'(1);
        end

        case (state_q)
            ST_IDLE: begin
                // First read goes out on the start edge to shorten time-to-first-word.
                if (start) begin
                    state_d    = ST_RUN;
                    clr_c      = 1'b1;
                    issue_c    = 1'b1;
                    rd_base_c  = '0;
                    word_cnt_d = '0;
                    poly_cnt_d = '0;
                end
            end
            ST_RUN:   issue_c = (committed_c <= CMT_W'(BUF_W - COEFF_WIDTH));
            ST_DRAIN: begin
                if (accept_c && (word_cnt_q == WORD_W'(TOTAL_WORDS - 1))) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        if (issue_c) begin
            addr_d   = ADDR_WIDTH'(rd_base_c);
            rd_cnt_d = rd_base_c + RD_W'(1);
            if (rd_base_c == RD_W'(NUM_COEFFS - 1)) begin
                state_d = ST_DRAIN;
            end
        end

        busy_d      = (state_d != ST_IDLE);
        done_d      = (state_d == ST_DONE);
        poly_last_d = acc_valid_nxt_c && (poly_cnt_d == PW'(POLY_WORDS - 1));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            rd_cnt_q    <= '0;
            addr_q      <= '0;
            iss_q       <= 1'b0;
            dat_q       <= 1'b0;
            word_cnt_q  <= '0;
            poly_cnt_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            poly_last_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_cnt_q    <= rd_cnt_d;
            addr_q      <= addr_d;
            iss_q       <= issue_c;
            dat_q       <= iss_q;
            word_cnt_q  <= word_cnt_d;
            poly_cnt_q  <= poly_cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            poly_last_q <= poly_last_d;
        end
    end

`ifdef BITPACK_RANGE_CHECK_EN
    localparam logic signed [COEFF_IN_W-1:0] G_POS = $signed(COEFF_IN_W'(1 << GAMMA1));
    localparam logic signed [COEFF_IN_W-1:0] G_NEG = -G_POS;

    logic err_q, err_d, range_bad_c;

    // Valid coefficients lie in (-2^GAMMA1, 2^GAMMA1]; the flag sticks until the next accepted start.
    always_comb begin
        range_bad_c = ($signed(dout_vector_y) <= G_NEG) || ($signed(dout_vector_y) > G_POS);
        err_d       = err_q;
        if (start_ok_c) begin
            err_d = 1'b0;
        end else if (dat_q && range_bad_c) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign done          = done_q;
    assign busy          = busy_q;
    assign addr_vector_y = addr_q;
    assign out_data      = acc_data;
    assign out_valid     = acc_valid;
    assign out_poly_last = poly_last_q;

endmodule

// File: tb/tb_bitpack_gamma1.sv
// Bench for bitpack_gamma1: RAM model, accepted-word monitor and a bit-level BitPack reference.
module tb_bitpack_gamma1;

    localparam int NC     = 7 * 256;
    localparam int NWORDS = 560;

    logic        clk = 1'b0;
    logic        rst, start, out_ready;
    logic        done, busy, out_valid, out_poly_last, err;
    logic [10:0] addr_vector_y;
    logic [23:0] dout_vector_y;
    logic [63:0] out_data;

    logic [23:0] mem [NC];
    logic [63:0] got_w [$];
    logic        got_l [$];
    int          done_cnt;
    int          n_checks = 0;
    int          n_pass   = 0;

    always #5 clk = ~clk;

    bitpack_gamma1 dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .done          (done),
        .busy          (busy),
        .addr_vector_y (addr_vector_y),
        .dout_vector_y (dout_vector_y),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_poly_last (out_poly_last),
        .err           (err)
    );

    always @(posedge clk) dout_vector_y <= mem[addr_vector_y];

    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            got_w.push_back(out_data);
            got_l.push_back(out_poly_last);
        end
        if (rst && done) done_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_checks++;
        assert (obs === exp_v) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    endtask

    // Stream bit j is bit (j mod 20) of t for coefficient j/20, with t = (2^19 - c) mod 2^20.
    function automatic logic [63:0] exp_word(input int k);
        logic [63:0] w;
        for (int b = 0; b < 64; b++) begin
            int j  = 64 * k + b;
            int c  = int'($signed(mem[j / 20]));
            int t  = ((1 << 19) - c) & 32'h000F_FFFF;
            w[b] = ((t >> (j % 20)) & 1) != 0;
        end
        return w;
    endfunction

    task automatic fill_const(input int v);
        for (int i = 0; i < NC; i++) mem[i] = 24'(v);
    endtask

    task automatic fill_random();
        for (int i = 0; i < NC; i++) mem[i] = 24'(int'($urandom_range(0, 1048575)) - 524287);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_data"},  out_data, 64'h0);
        check({tag, "_valid"}, 64'(out_valid), 64'h0);
        check({tag, "_busy"},  64'(busy), 64'h0);
        check({tag, "_done"},  64'(done), 64'h0);
        check({tag, "_last"},  64'(out_poly_last), 64'h0);
        check({tag, "_err"},   64'(err), 64'h0);
        check({tag, "_addr"},  64'(addr_vector_y), 64'h0);
    endtask

    task automatic pulse_start();
        got_w.delete();
        got_l.delete();
        done_cnt  = 0;
        out_ready = 1'b1;
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic do_run(input bit hold10, input bit rnd_ready, input bit extra_start);
        int          n;
        bit          held;
        logic [63:0] d0;
        logic        v0;
        pulse_start();
        check("busy_after_start", 64'(busy), 64'h1);
        check("err_clear_on_start", 64'(err), 64'h0);
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("first_valid_within_5", 64'(n <= 5), 64'h1);
        held = 1'b0;
        for (int cyc = 0; cyc < 8000 && done_cnt == 0; cyc++) begin
            start     = (extra_start && cyc == 40);
            out_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (hold10 && !held && got_w.size() >= 100 && out_valid) begin
                held      = 1'b1;
                out_ready = 1'b0;
                d0        = out_data;
                v0        = out_valid;
                for (int h = 0; h < 10; h++) begin
                    @(posedge clk); #1;
                    check("hold_data", out_data, d0);
                    check("hold_valid", 64'(out_valid), 64'(v0));
                end
                out_ready = 1'b1;
            end
            @(posedge clk); #1;
        end
        start     = 1'b0;
        out_ready = 1'b1;
        check("done_before_timeout", 64'(done_cnt != 0), 64'h1);
        repeat (4) @(posedge clk);
        #1;
        check("done_pulse_count", 64'(done_cnt), 64'd1);
        check("word_count", 64'(got_w.size()), 64'(NWORDS));
        check("busy_low_after_done", 64'(busy), 64'h0);
        for (int k = 0; k < got_w.size(); k++) begin
            check($sformatf("word%0d", k), got_w[k], exp_word(k));
            check($sformatf("poly_last%0d", k), 64'(got_l[k]), 64'((k % 80) == 79));
        end
    endtask

    initial begin
        int n;
        rst       = 1'b0;
        start     = 1'b0;
        out_ready = 1'b0;
        done_cnt  = 0;
        fill_const(0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1;
        rst = 1'b1;

        // All-zero coefficients: every field is 0x80000.
        fill_const(0);
        do_run(1'b0, 1'b0, 1'b0);
        check("zero_word0_const", got_w.size() > 0 ? got_w[0] : 64'hx, 64'h0800_0080_0008_0000);

        // Coefficient 2^19 maps to t = 0.
        fill_const(524288);
        do_run(1'b0, 1'b0, 1'b0);
        check("max_last_word_const", got_w.size() > 0 ? got_w[got_w.size() - 1] : 64'hx, 64'h0);

        // Coefficient -(2^19-1) maps to t = 0xFFFFF.
        fill_const(-524287);
        do_run(1'b0, 1'b0, 1'b0);
        check("min_word0_const", got_w.size() > 0 ? got_w[0] : 64'hx, 64'hFFFF_FFFF_FFFF_FFFF);

        // Random data, random back-pressure, a 10-cycle stall and a start pulse while busy.
        fill_random();
        do_run(1'b1, 1'b1, 1'b1);

        // Reset in the middle of a run, then a complete fresh run.
        fill_random();
        pulse_start();
        n = 0;
        while (got_w.size() < 200 && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        check("reached_word_200", 64'(got_w.size() >= 200), 64'h1);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_all_zero("midrun_reset");
        @(posedge clk); #1;
        rst = 1'b1;
        fill_random();
        do_run(1'b0, 1'b0, 1'b0);

        // Out-of-range coefficient at index 37.
        fill_random();
        mem[37] = 24'(-524288);
        do_run(1'b0, 1'b0, 1'b0);
`ifdef BITPACK_RANGE_CHECK_EN
        check("err_after_bad_coeff", 64'(err), 64'h1);
        repeat (5) @(posedge clk);
        #1;
        check("err_sticky", 64'(err), 64'h1);
`else
        check("err_after_bad_coeff", 64'(err), 64'h0);
        repeat (5) @(posedge clk);
        #1;
        check("err_sticky", 64'(err), 64'h0);
`endif
        fill_random();
        do_run(1'b0, 1'b1, 1'b0);
        check("err_after_clean_run", 64'(err), 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
